// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Shift-add multiplier and restoring divider, one result bit per cycle,
// valid/ready handshake on both sides, result held until taken.
// Optional feature macro: ALU_MULDIV_EARLY_OUT_EN (trivial cases skip the iteration phase).
module alu_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic [2:0]            MulDivOp_i,
    input  logic [DATA_WIDTH-1:0] SrcA_i,
    input  logic [DATA_WIDTH-1:0] SrcB_i,
    input  logic                  Flush_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [DATA_WIDTH-1:0] Result_o,
    output logic                  Busy_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LP_CNT_INIT = CW'(DATA_WIDTH);
    localparam logic [W-1:0]  LP_MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [W-1:0]     r_mag_a;
    logic [W-1:0]     r_mag_b;
    logic [W-1:0]     r_src_a;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_div_zero;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_result;

    // Operand decode at acceptance: signedness, magnitudes, special cases
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_mag_a;
    logic [W-1:0]     w_mag_b;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_early;

    assign w_is_div   = MulDivOp_i[2];
    assign w_a_signed = (MulDivOp_i == 3'b001) || (MulDivOp_i == 3'b010) ||
                        (MulDivOp_i == 3'b100) || (MulDivOp_i == 3'b110);
    assign w_b_signed = (MulDivOp_i == 3'b001) || (MulDivOp_i == 3'b100) ||
                        (MulDivOp_i == 3'b110);
    assign w_a_neg    = w_a_signed & SrcA_i[W-1];
    assign w_b_neg    = w_b_signed & SrcB_i[W-1];
    // The most-negative value maps to 2^(W-1), which still fits as unsigned
    assign w_mag_a    = w_a_neg ? (~SrcA_i + 1'b1) : SrcA_i;
    assign w_mag_b    = w_b_neg ? (~SrcB_i + 1'b1) : SrcB_i;
    assign w_div_zero = (SrcB_i == '0);
    assign w_ovf      = w_is_div && !MulDivOp_i[0] &&
                        (SrcA_i == LP_MOST_NEG) && (SrcB_i == '1);

`ifdef ALU_MULDIV_EARLY_OUT_EN
    // Results of these cases are fully determined without iterating
    assign w_early = w_is_div ? (w_div_zero || w_ovf)
                              : ((SrcA_i == '0) || (SrcB_i == '0));
`else
    assign w_early = 1'b0;
`endif

    // One shift-add multiply step: acc = {partial product, remaining multiplier}
    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_next;
    assign w_mul_sum  = r_acc[0] ? ({1'b0, r_acc[2*W-1:W]} + {1'b0, r_mag_a})
                                 : {1'b0, r_acc[2*W-1:W]};
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // One restoring divide step: acc = {remainder, dividend/quotient}
    logic [W:0]       w_shift_rem;
    logic [W:0]       w_trial;
    logic             w_q_bit;
    logic [2*W-1:0]   w_div_next;
    assign w_shift_rem = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_mag_b};
    assign w_q_bit     = ~w_trial[W];
    assign w_div_next  = {(w_q_bit ? w_trial[W-1:0] : w_shift_rem[W-1:0]),
                          r_acc[W-2:0], w_q_bit};

    // Sign correction of the finished magnitudes
    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_quot;
    logic [W-1:0]     w_rem;
    assign w_prod = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot = r_neg_res ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
    assign w_rem  = r_neg_rem ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];

    // Result select with divide special-case overrides
    logic [W-1:0]     w_sign_result;
    always_comb begin
        w_sign_result = '0;
        if (!r_op[2]) begin
            w_sign_result = (r_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
        end else if (!r_op[1]) begin
            if (r_div_zero)  w_sign_result = '1;
            else if (r_ovf)  w_sign_result = r_src_a;
            else             w_sign_result = w_quot;
        end else begin
            if (r_div_zero)  w_sign_result = r_src_a;
            else if (r_ovf)  w_sign_result = '0;
            else             w_sign_result = w_rem;
        end
    end

    // Control FSM and datapath registers; flush wins over every other transition
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_src_a    <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_result   <= '0;
        end else if (Flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Valid_i) begin
                        r_op       <= MulDivOp_i;
                        r_mag_a    <= w_mag_a;
                        r_mag_b    <= w_mag_b;
                        r_src_a    <= SrcA_i;
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= w_div_zero;
                        r_ovf      <= w_ovf;
                        r_cnt      <= LP_CNT_INIT;
                        if (w_early)
                            r_acc <= '0;
                        else if (w_is_div)
                            r_acc <= {{W{1'b0}}, w_mag_a};
                        else
                            r_acc <= {{W{1'b0}}, w_mag_b};
                        r_state    <= w_early ? S_SIGN : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                    if (r_cnt == CW'(1))
                        r_state <= S_SIGN;
                end
                S_SIGN: begin
                    r_result <= w_sign_result;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (Ready_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Ready_o  = (r_state == S_IDLE);
    assign Valid_o  = (r_state == S_DONE);
    assign Busy_o   = (r_state == S_BUSY) || (r_state == S_SIGN);
    assign Result_o = r_result;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (DATA_WIDTH = 32), hand-computed expectations.
module tb_alu_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        Valid_i = 1'b0;
    logic        Ready_o;
    logic [2:0]  MulDivOp_i = 3'b000;
    logic [31:0] SrcA_i = '0;
    logic [31:0] SrcB_i = '0;
    logic        Flush_i = 1'b0;
    logic        Valid_o;
    logic        Ready_i = 1'b0;
    logic [31:0] Result_o;
    logic        Busy_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_res;

`ifdef ALU_MULDIV_EARLY_OUT_EN
    localparam int LAT_SPEC = 1;
`else
    localparam int LAT_SPEC = 33;
`endif
    localparam int LAT_FULL = 33;

    alu_muldiv #(.DATA_WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .Valid_i    (Valid_i),
        .Ready_o    (Ready_o),
        .MulDivOp_i (MulDivOp_i),
        .SrcA_i     (SrcA_i),
        .SrcB_i     (SrcB_i),
        .Flush_i    (Flush_i),
        .Valid_o    (Valid_o),
        .Ready_i    (Ready_i),
        .Result_o   (Result_o),
        .Busy_o     (Busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after E0
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        chk({tag, " ready_before"}, {31'd0, Ready_o}, 32'd1);
        MulDivOp_i = op;
        SrcA_i     = a;
        SrcB_i     = b;
        Valid_i    = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        Valid_i    = 1'b0;
        SrcA_i     = 32'hDEAD_BEEF;
        SrcB_i     = 32'h0BAD_F00D;
        MulDivOp_i = 3'b111;
    endtask

    // Count edges from E0 to Valid_o and cycles with Busy_o high
    task automatic wait_done(input int exp_lat, input string tag);
        int n;
        int busy_n;
        n = 0;
        busy_n = 0;
        while (!Valid_o && n < 100) begin
            if (Busy_o) busy_n++;
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string tag);
        issue(op, a, b, tag);
        wait_done(exp_lat, tag);
        chk({tag, " result"}, Result_o, exp);
        Ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        Ready_i = 1'b0;
        chk({tag, " ready_after"}, {31'd0, Ready_o}, 32'd1);
        chk({tag, " valid_after"}, {31'd0, Valid_o}, 32'd0);
        last_res = exp;
        $display("[TB] %s op=%b a=%h b=%h result=%h", tag, op, a, b, Result_o);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("reset ready", {31'd0, Ready_o}, 32'd1);
        chk("reset valid", {31'd0, Valid_o}, 32'd0);
        chk("reset busy", {31'd0, Busy_o}, 32'd0);
        chk("reset result", Result_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Multiply family
        run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_FULL, "MUL 7*-3");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_FULL, "MULH min*min");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL, "MULHU max*max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT_FULL, "MULHSU -1*2");
        run_op(3'b000, 32'h1234_5678, 32'd0,        32'd0,         LAT_SPEC, "MUL x*0");

        // Divide family
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_FULL, "DIV -7/2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_FULL, "REM -7/2");
        run_op(3'b101, 32'd100,       32'd7, 32'd14,        LAT_FULL, "DIVU 100/7");
        run_op(3'b111, 32'd100,       32'd7, 32'd2,         LAT_FULL, "REMU 100/7");

        // Special cases
        run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC, "DIV 5/0");
        run_op(3'b110, 32'd5, 32'd0, 32'd5,         LAT_SPEC, "REM 5/0");
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPEC, "DIVU 5/0");
        run_op(3'b111, 32'd5, 32'd0, 32'd5,         LAT_SPEC, "REMU 5/0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC, "DIV ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPEC, "REM ovf");

        // Back-pressure: result held while the consumer stalls
        issue(3'b101, 32'd100, 32'd7, "BP");
        wait_done(LAT_FULL, "BP");
        for (int i = 0; i < 5; i++) begin
            chk("BP hold result", Result_o, 32'd14);
            chk("BP hold ready", {31'd0, Ready_o}, 32'd0);
            chk("BP hold valid", {31'd0, Valid_o}, 32'd1);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        Ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        Ready_i = 1'b0;
        chk("BP release ready", {31'd0, Ready_o}, 32'd1);
        chk("BP release valid", {31'd0, Valid_o}, 32'd0);
        last_res = 32'd14;
        $display("[TB] BP DIVU 100/7 held 5 cycles result=%h", Result_o);

        // Flush at iteration 10
        issue(3'b000, 32'd3, 32'd5, "FLUSH");
        repeat (9) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        Flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        Flush_i = 1'b0;
        chk("FLUSH ready", {31'd0, Ready_o}, 32'd1);
        chk("FLUSH valid", {31'd0, Valid_o}, 32'd0);
        chk("FLUSH busy", {31'd0, Busy_o}, 32'd0);
        chk("FLUSH result held", Result_o, last_res);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (Valid_o) seen++;
                @(posedge clk_i);
                @(negedge clk_i);
            end
            chk("FLUSH no valid", 32'(seen), 32'd0);
        end
        $display("[TB] FLUSH at iteration 10 result=%h", Result_o);

        // Flush together with a request in IDLE: not accepted
        MulDivOp_i = 3'b000;
        SrcA_i = 32'd9;
        SrcB_i = 32'd9;
        Valid_i = 1'b1;
        Flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        Valid_i = 1'b0;
        Flush_i = 1'b0;
        chk("FLUSH+VALID ready", {31'd0, Ready_o}, 32'd1);
        chk("FLUSH+VALID busy", {31'd0, Busy_o}, 32'd0);
        $display("[TB] FLUSH+VALID in IDLE busy=%b", Busy_o);

        // Asynchronous reset mid-operation
        issue(3'b100, 32'd1000, 32'd3, "RST");
        repeat (5) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        chk("RST busy before", {31'd0, Busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("RST ready", {31'd0, Ready_o}, 32'd1);
        chk("RST valid", {31'd0, Valid_o}, 32'd0);
        chk("RST busy", {31'd0, Busy_o}, 32'd0);
        chk("RST result", Result_o, 32'd0);
        $display("[TB] RST mid-busy result=%h", Result_o);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Recovery after reset
        run_op(3'b100, 32'd1000, 32'd3, 32'd333, LAT_FULL, "DIV after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised iterative multiply/divide unit that extends the single-cycle integer ALU with the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake and computes one result bit per cycle using a shift-add multiplier and a restoring divider. It holds the result until the consumer takes it.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; legal values are 8 or more.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_ni, input, 1, reset; asynchronous, active-low.
- Valid_i, input, 1, operation request.
- Ready_o, output, 1, unit can accept; high only in IDLE.
- MulDivOp_i, input, 3, operation; equals RISC-V funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA_i, input, DATA_WIDTH, rs1 operand (multiplicand/dividend).
- SrcB_i, input, DATA_WIDTH, rs2 operand (multiplier/divisor).
- Flush_i, input, 1, synchronous kill of any in-flight operation.
- Valid_o, output, 1, Result_o valid; high only in DONE.
- Ready_i, input, 1, consumer takes result.
- Result_o, output, DATA_WIDTH, registered result.
- Busy_o, output, 1, high in BUSY or SIGN.

## Operation
- States: IDLE, BUSY, SIGN, DONE.
- IDLE → BUSY when Valid_i && Ready_o && !Flush_i.
  - Latch the op, the operand magnitudes and the result-sign flags.
  - Load the iteration counter (width $clog2(DATA_WIDTH)+1) with DATA_WIDTH.
- BUSY: one iteration per cycle, counter decrements each cycle. On the edge where the counter reaches 0, move to SIGN.
  - Multiply: 2×DATA_WIDTH accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring shift-subtract; quotient bit = 1 when the trial remainder is ≥ 0.
- Signedness rules:
  - Signed: MULH (both operands), MULHSU (SrcA only), DIV/REM (both operands).
  - Negate the product when operand signs differ.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
- Result select:
  - MUL: low DATA_WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high DATA_WIDTH bits of the product.
- SIGN: apply sign correction and special-case overrides, register Result_o, then move to DONE.
- Special cases (override applies regardless of the macro):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = −1) for DIV: quotient = SrcA, REM = 0.
- DONE: Valid_o = 1 and Result_o is held stable. On an edge with Ready_i = 1, move to IDLE.
- Flush_i = 1 in any state: next state is IDLE, Valid_o drops, Result_o is held.
  - Flush_i has priority over accept and over Ready_i.
- rst_ni low (any time, including mid-operation) immediately forces:
  - IDLE
  - Ready_o = 1, Valid_o = 0, Busy_o = 0
  - Result_o = 0, counter = 0

## Timing
- The accepting edge is E0. Iterations happen on E1..E(DATA_WIDTH). SIGN registers the result on E(DATA_WIDTH+1).
- Valid_o is high from E(DATA_WIDTH+1). For DATA_WIDTH = 32 this is 33 edges after acceptance.
- Ready_o is low from E0 until the edge after the DONE handshake.
- Minimum issue interval is DATA_WIDTH+3 cycles; there is no back-to-back acceptance.
- Valid_i is ignored when Ready_o = 0. Operands need only be valid during the accepting cycle.
- Outputs are combinational from state and registers only. There is no combinational path from inputs to outputs.

## Configuration
- ALU_MULDIV_EARLY_OUT_EN defined:
  - Divide-by-zero and signed-overflow cases skip BUSY: IDLE → SIGN on E0, Valid_o high from E1.
  - MUL/MULH* with either operand equal to 0 also skips BUSY and returns 0.
- Undefined: every operation takes the full DATA_WIDTH+1 edge latency. Results are identical in both configurations.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → Result_o = 0xFFFFFFEB; Valid_o rises exactly 33 edges after acceptance; Busy_o high for 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - With ALU_MULDIV_EARLY_OUT_EN: Valid_o after 1 edge. Without: after 33 edges.
- Back-pressure: hold Ready_i = 0 for 5 cycles after Valid_o → Result_o stable, Ready_o = 0 throughout; then Ready_i = 1 → IDLE, Ready_o = 1 one edge later.
- Flush_i pulsed at iteration 10 → Valid_o stays 0, Ready_o = 1 after the next edge.
  - Flush_i together with Valid_i in IDLE → request not accepted.
  - rst_ni low mid-BUSY → all outputs at reset values immediately.
